// File: rtl/seq_frame_tx_if.sv
// Payload handshake and serial output bundle for seq_frame_tx.
// The master side offers payload words; the slave side (the transmitter)
// returns ready and the serial stream.
interface seq_frame_tx_if #(
  parameter int DATA_W = 8
) ();
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              xout;
  logic              xvalid;
  logic              tx_done;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  xout,
    input  xvalid,
    input  tx_done
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output xout,
    output xvalid,
    output tx_done
  );
endinterface

// File: rtl/seq_frame_tx.sv
// Serial frame transmitter: sends the SYNC_PAT preamble, then the payload
// MSB-first, then GAP_CYC idle cycles. All serial outputs are registered, so
// the next-cycle value of xout/xvalid/tx_done is decided together with the
// next state.
module seq_frame_tx #(
  parameter int                DATA_W   = 8,
  parameter int                SYNC_W   = 4,
  parameter logic [SYNC_W-1:0] SYNC_PAT = 4'b1011,
  parameter int                GAP_CYC  = 2
) (
  input  logic          clk,
  input  logic          rst,
  seq_frame_tx_if.slave bus
);

  localparam int MAX_A   = (SYNC_W > DATA_W) ? SYNC_W : DATA_W;
  localparam int MAX_B   = (MAX_A > GAP_CYC) ? MAX_A : GAP_CYC;
  localparam int CNT_MAX = (MAX_B > 1) ? MAX_B : 1;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;
  localparam int IDX_W   = (SYNC_W > 1) ? $clog2(SYNC_W) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    DATA = 2'd2,
    GAP  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  shift_q, shift_d;
  logic               xout_q, xout_d;
  logic               xvalid_q, xvalid_d;
  logic               tx_done_q, tx_done_d;
  logic [IDX_W-1:0]   pat_idx;

  // Next-state and next-output decode; each branch loads the bit that will be on xout next cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    xout_d    = 1'b0;
    xvalid_d  = 1'b0;
    tx_done_d = 1'b0;
    // Preamble bit following the one currently on the line (k+1 when sending bit k).
    pat_idx   = IDX_W'(SYNC_W - 2) - IDX_W'(cnt_q);

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d  = SYNC;
          cnt_d    = '0;
          shift_d  = bus.in_data;
          xvalid_d = 1'b1;
          xout_d   = SYNC_PAT[SYNC_W-1];
        end
      end
      SYNC: begin
        xvalid_d = 1'b1;
        if (cnt_q == CNT_W'(SYNC_W - 1)) begin
          state_d = DATA;
          cnt_d   = '0;
          xout_d  = shift_q[DATA_W-1];
          shift_d = shift_q << 1;
        end else begin
          cnt_d  = cnt_q + 1'b1;
          xout_d = SYNC_PAT[pat_idx];
        end
      end
      DATA: begin
        if (cnt_q == CNT_W'(DATA_W - 1)) begin
          // Last payload bit is on the line now; tx_done rides the cycle after it.
          cnt_d     = '0;
          tx_done_d = 1'b1;
          state_d   = (GAP_CYC > 0) ? GAP : IDLE;
        end else begin
          cnt_d    = cnt_q + 1'b1;
          xvalid_d = 1'b1;
          xout_d   = shift_q[DATA_W-1];
          shift_d  = shift_q << 1;
        end
      end
      GAP: begin
        if (cnt_q == CNT_W'(GAP_CYC - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter, payload and registered serial outputs; active-low reset abandons any frame.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      xout_q    <= 1'b0;
      xvalid_q  <= 1'b0;
      tx_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      xout_q    <= xout_d;
      xvalid_q  <= xvalid_d;
      tx_done_q <= tx_done_d;
    end
  end

  assign bus.in_ready = (state_q == IDLE);
  assign bus.xout     = xout_q;
  assign bus.xvalid   = xvalid_q;
  assign bus.tx_done  = tx_done_q;

endmodule

// File: tb/tb_seq_frame_tx.sv
// Directed bench for seq_frame_tx: a default instance (8-bit payload, 2-cycle
// gap) and a 4-bit, zero-gap instance. Expected serial bits are queued when a
// word is offered and popped as the transmitter emits them.
module tb_seq_frame_tx;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seq_frame_tx_if #(.DATA_W(8)) bus1 ();
  seq_frame_tx_if #(.DATA_W(4)) bus2 ();

  seq_frame_tx u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  seq_frame_tx #(.DATA_W(4), .GAP_CYC(0)) u_dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  logic q[$];

  // Far-end 1011 detector model fed by the default instance's xout.
  logic [2:0] hist;
  logic       zout;
  always @(posedge clk) hist <= {hist[1:0], bus1.xout};
  assign zout = (hist == 3'b101) && bus1.xout;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input logic [7:0] d, input int w);
    q.push_back(1'b1); q.push_back(1'b0); q.push_back(1'b1); q.push_back(1'b1);
    for (int i = w - 1; i >= 0; i--) q.push_back(d[i]);
  endtask

  // Default instance: step through nbits serial cycles, starting at the accept edge.
  task automatic expect_frame(input string tag, input int nbits, input bit hold,
                              input logic [7:0] nd, output int start);
    logic e;
    start = 0;
    for (int i = 0; i < nbits; i++) begin
      step();
      if (i == 0) begin
        start = cyc;
        if (!hold) bus1.in_valid = 1'b0;
        bus1.in_data = nd;
      end
      e = (q.size() > 0) ? q.pop_front() : 1'bx;
      check({tag, "_xvalid"}, bus1.xvalid, 1);
      check({tag, "_xout"}, bus1.xout, e);
      check({tag, "_in_ready"}, bus1.in_ready, 0);
    end
  endtask

  // Default instance: tx_done cycle, remaining gap cycle, then ready again.
  task automatic tail(input string tag);
    step();
    check({tag, "_tx_done"}, bus1.tx_done, 1);
    check({tag, "_gap0_xvalid"}, bus1.xvalid, 0);
    check({tag, "_gap0_xout"}, bus1.xout, 0);
    check({tag, "_gap0_ready"}, bus1.in_ready, 0);
    step();
    check({tag, "_gap1_tx_done"}, bus1.tx_done, 0);
    check({tag, "_gap1_xvalid"}, bus1.xvalid, 0);
    check({tag, "_gap1_ready"}, bus1.in_ready, 0);
    step();
    check({tag, "_ready_back"}, bus1.in_ready, 1);
    check({tag, "_sb_empty"}, q.size(), 0);
  endtask

  initial begin
    int s0, s1, cnt, z1, z2;
    logic e;
    int st2[2];

    rst           = 1'b0;
    bus1.in_valid = 1'b1;
    bus1.in_data  = 8'hA5;
    bus2.in_valid = 1'b0;
    bus2.in_data  = 4'h0;
    step();
    step();
    check("rst_xvalid", bus1.xvalid, 0);
    check("rst_xout", bus1.xout, 0);
    check("rst_tx_done", bus1.tx_done, 0);
    check("rst_in_ready", bus1.in_ready, 1);
    check("rst_xvalid2", bus2.xvalid, 0);
    check("rst_in_ready2", bus2.in_ready, 1);

    // Single frame of A5 accepted on the first cycle after release.
    rst = 1'b1;
    push_frame(8'hA5, 8);
    expect_frame("a5", 12, 1'b0, 8'hA5, s0);
    tail("a5");

    // in_valid held: 00 then FF, back-to-back.
    bus1.in_valid = 1'b1;
    bus1.in_data  = 8'h00;
    push_frame(8'h00, 8);
    push_frame(8'hFF, 8);
    expect_frame("b2b0", 12, 1'b1, 8'hFF, s0);
    step();
    check("b2b0_tx_done", bus1.tx_done, 1);
    step();
    step();
    check("b2b0_ready", bus1.in_ready, 1);
    expect_frame("b2b1", 12, 1'b1, 8'hFF, s1);
    bus1.in_valid = 1'b0;
    check("b2b_period", s1 - s0, 15);
    tail("b2b1");
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      cnt += int'(bus1.xvalid);
    end
    check("b2b_no_dup", cnt, 0);

    // Payload latched at accept; later in_data changes are ignored.
    bus1.in_valid = 1'b1;
    bus1.in_data  = 8'h3C;
    push_frame(8'h3C, 8);
    expect_frame("latch", 12, 1'b0, 8'hFF, s0);
    tail("latch");

    // Reset asserted during payload bit 3 of A5.
    bus1.in_valid = 1'b1;
    bus1.in_data  = 8'hA5;
    push_frame(8'hA5, 8);
    for (int i = 0; i < 8; i++) begin
      step();
      if (i == 0) bus1.in_valid = 1'b0;
      e = (q.size() > 0) ? q.pop_front() : 1'bx;
      check("midrst_xout", bus1.xout, e);
    end
    rst = 1'b0;
    step();
    check("midrst_xvalid", bus1.xvalid, 0);
    check("midrst_xout0", bus1.xout, 0);
    check("midrst_ready", bus1.in_ready, 1);
    check("midrst_tx_done", bus1.tx_done, 0);
    rst = 1'b1;
    q.delete();
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      cnt += int'(bus1.tx_done) + int'(bus1.xvalid);
    end
    check("midrst_no_residue", cnt, 0);
    bus1.in_valid = 1'b1;
    bus1.in_data  = 8'hA5;
    push_frame(8'hA5, 8);
    expect_frame("fresh", 12, 1'b0, 8'hA5, s0);
    tail("fresh");

    // Zero-gap, 4-bit instance: back-to-back 9.
    bus2.in_valid = 1'b1;
    bus2.in_data  = 4'h9;
    push_frame(8'h09, 4);
    push_frame(8'h09, 4);
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 8; i++) begin
        step();
        if (i == 0) st2[f] = cyc;
        e = (q.size() > 0) ? q.pop_front() : 1'bx;
        check("g0_xvalid", bus2.xvalid, 1);
        check("g0_xout", bus2.xout, e);
      end
      if (f == 1) bus2.in_valid = 1'b0;
      step();
      check("g0_tx_done", bus2.tx_done, 1);
      check("g0_ready_with_done", bus2.in_ready, 1);
      check("g0_idle_xvalid", bus2.xvalid, 0);
    end
    check("g0_period", st2[1] - st2[0], 9);
    step();
    check("g0_done_once", bus2.tx_done, 0);
    check("g0_no_third", bus2.xvalid, 0);
    check("g0_sb_empty", q.size(), 0);

    // Loopback into the 1011 detector, two frames of 00.
    bus1.in_valid = 1'b1;
    bus1.in_data  = 8'h00;
    cnt = 0;
    z1  = -1;
    z2  = -1;
    for (int i = 1; i <= 30; i++) begin
      step();
      if (zout === 1'b1) begin
        cnt++;
        if (cnt == 1) z1 = i;
        else z2 = i;
      end
      if (i == 16) bus1.in_valid = 1'b0;
    end
    check("det_count", cnt, 2);
    check("det_first", z1, 4);
    check("det_second", z2, 19);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
